// File: rtl/usb_desc_reader_if.sv
// EP0 IN byte stream between the descriptor reader and the endpoint buffer.
// Signal names are given from the reader's point of view.
interface usb_desc_reader_if;
    logic [7:0] o_txdat;
    logic       o_txval;
    logic       o_txlast;
    logic       i_txrdy;

    modport master (
        output o_txdat,
        output o_txval,
        output o_txlast,
        input  i_txrdy
    );

    modport slave (
        input  o_txdat,
        input  o_txval,
        input  o_txlast,
        output i_txrdy
    );
endinterface

// File: rtl/usb_desc_reader.sv
// GET_DESCRIPTOR streamer: resolves the descriptor from the ROM map, then sends it
// to EP0 IN in MAXPKT packets, truncated to wLength, with ZLP or stall when required.
module usb_desc_reader #(
    parameter int MAXPKT    = 64,
    parameter bit HSSUPPORT = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 i_abort,
    input  logic                 i_start,
    input  logic [7:0]           i_desc_type,
    input  logic [7:0]           i_desc_index,
    input  logic [15:0]          i_wlength,
    input  logic                 i_hs_mode,
    input  logic                 i_in_req,
    output logic [9:0]           o_descrom_raddr,
    input  logic [7:0]           i_descrom_rdat,
    input  logic [9:0]           i_desc_dev_addr,
    input  logic [7:0]           i_desc_dev_len,
    input  logic [9:0]           i_desc_hscfg_addr,
    input  logic [7:0]           i_desc_hscfg_len,
    input  logic [9:0]           i_desc_fscfg_addr,
    input  logic [7:0]           i_desc_fscfg_len,
    input  logic [9:0]           i_desc_qual_addr,
    input  logic [7:0]           i_desc_qual_len,
    input  logic [9:0]           i_desc_strlang_addr,
    input  logic [9:0]           i_desc_vendor_addr,
    input  logic [7:0]           i_desc_vendor_len,
    input  logic [9:0]           i_desc_product_addr,
    input  logic [7:0]           i_desc_product_len,
    input  logic [9:0]           i_desc_serial_addr,
    input  logic [7:0]           i_desc_serial_len,
    input  logic                 i_descrom_have_strings,
    usb_desc_reader_if.master    tx,
    output logic                 o_zlp,
    output logic                 o_stall,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int PKTW = $clog2(MAXPKT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WAIT_IN, S_SEND, S_ZLP_WAIT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  type_q, type_d;
    logic [7:0]  index_q, index_d;
    logic [15:0] wlength_q, wlength_d;
    logic        hs_q, hs_d;
    logic [9:0]  raddr_q, raddr_d;
    logic [9:0]  base_q, base_d;
    logic        osp_q, osp_d;
    logic [15:0] remaining_q, remaining_d;
    logic [6:0]  pkt_cnt_q, pkt_cnt_d;
    logic        need_zlp_q, need_zlp_d;
    logic [7:0]  txdat_q, txdat_d;
    logic        txval_q, txval_d;
    logic        txlast_q, txlast_d;
    logic        zlp_q, zlp_d;
    logic        stall_q, stall_d;

    logic [9:0]  lk_base;
    logic [7:0]  lk_len;
    logic        lk_stall;
    logic        lk_osp;
    logic [15:0] xfer_len;
    logic        need_zlp;
    logic [7:0]  rom_byte;
    logic [6:0]  pkt_first;
    logic        last_acc;

    always_comb begin
        lk_base  = '0;
        lk_len   = '0;
        lk_stall = 1'b0;
        lk_osp   = 1'b0;
        case (type_q)
            8'd1: begin
                lk_base = i_desc_dev_addr;
                lk_len  = i_desc_dev_len;
            end
            8'd2: begin
                lk_base = hs_q ? i_desc_hscfg_addr : i_desc_fscfg_addr;
                lk_len  = hs_q ? i_desc_hscfg_len  : i_desc_fscfg_len;
            end
            8'd3: begin
                if (!i_descrom_have_strings || index_q > 8'd3) begin
                    lk_stall = 1'b1;
                end else begin
                    case (index_q[1:0])
                        2'd0: begin lk_base = i_desc_strlang_addr; lk_len = 8'd4;               end
                        2'd1: begin lk_base = i_desc_vendor_addr;  lk_len = i_desc_vendor_len;  end
                        2'd2: begin lk_base = i_desc_product_addr; lk_len = i_desc_product_len; end
                        default: begin lk_base = i_desc_serial_addr; lk_len = i_desc_serial_len; end
                    endcase
                end
            end
            8'd6: begin
                lk_stall = !HSSUPPORT;
                lk_base  = i_desc_qual_addr;
                lk_len   = i_desc_qual_len;
            end
            8'd7: begin
                // Other-speed config is the config of the speed we are not running at.
                lk_stall = !HSSUPPORT;
                lk_osp   = 1'b1;
                lk_base  = hs_q ? i_desc_fscfg_addr : i_desc_hscfg_addr;
                lk_len   = hs_q ? i_desc_fscfg_len  : i_desc_hscfg_len;
            end
            default: lk_stall = 1'b1;
        endcase
    end

    always_comb begin
        xfer_len  = ({8'd0, lk_len} < wlength_q) ? {8'd0, lk_len} : wlength_q;
        need_zlp  = (xfer_len < wlength_q) && (xfer_len[PKTW-1:0] == '0);
        rom_byte  = (osp_q && (raddr_q - base_q) == 10'd1) ? 8'h07 : i_descrom_rdat;
        pkt_first = (remaining_q < 16'(MAXPKT)) ? remaining_q[6:0] : 7'(MAXPKT);
        last_acc  = txval_q && txlast_q && tx.i_txrdy;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (i_start) state_d = S_LOOKUP;
            S_LOOKUP:   state_d = lk_stall ? S_IDLE : S_WAIT_IN;
            S_WAIT_IN: begin
                if (remaining_q == 16'd0) state_d = need_zlp_q ? S_ZLP_WAIT : S_DONE;
                else if (i_in_req)        state_d = S_SEND;
            end
            S_SEND:     if (last_acc) state_d = S_WAIT_IN;
            S_ZLP_WAIT: if (i_in_req) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (i_abort) state_d = S_IDLE;
    end

    always_comb begin
        type_d      = type_q;
        index_d     = index_q;
        wlength_d   = wlength_q;
        hs_d        = hs_q;
        raddr_d     = raddr_q;
        base_d      = base_q;
        osp_d       = osp_q;
        remaining_d = remaining_q;
        pkt_cnt_d   = pkt_cnt_q;
        need_zlp_d  = need_zlp_q;
        txdat_d     = txdat_q;
        txval_d     = txval_q;
        txlast_d    = txlast_q;
        zlp_d       = 1'b0;
        stall_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    type_d    = i_desc_type;
                    index_d   = i_desc_index;
                    wlength_d = i_wlength;
                    hs_d      = i_hs_mode;
                end
            end
            S_LOOKUP: begin
                base_d      = lk_base;
                raddr_d     = lk_base;
                osp_d       = lk_osp;
                remaining_d = xfer_len;
                need_zlp_d  = need_zlp;
                stall_d     = lk_stall;
            end
            S_WAIT_IN: begin
                // First byte is loaded with the IN request so o_txval follows one cycle later.
                if (remaining_q != 16'd0 && i_in_req) begin
                    txval_d     = 1'b1;
                    txdat_d     = rom_byte;
                    txlast_d    = (pkt_first == 7'd1);
                    raddr_d     = raddr_q + 10'd1;
                    remaining_d = remaining_q - 16'd1;
                    pkt_cnt_d   = pkt_first - 7'd1;
                end
            end
            S_SEND: begin
                if (last_acc) begin
                    txval_d  = 1'b0;
                    txlast_d = 1'b0;
                end else if ((!txval_q || tx.i_txrdy) && pkt_cnt_q != 7'd0) begin
                    txval_d     = 1'b1;
                    txdat_d     = rom_byte;
                    txlast_d    = (pkt_cnt_q == 7'd1);
                    raddr_d     = raddr_q + 10'd1;
                    remaining_d = remaining_q - 16'd1;
                    pkt_cnt_d   = pkt_cnt_q - 7'd1;
                end
            end
            S_ZLP_WAIT: zlp_d = i_in_req;
            default: ;
        endcase
        if (i_abort) begin
            txval_d  = 1'b0;
            txlast_d = 1'b0;
            zlp_d    = 1'b0;
            stall_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            type_q      <= '0;
            index_q     <= '0;
            wlength_q   <= '0;
            hs_q        <= 1'b0;
            raddr_q     <= '0;
            base_q      <= '0;
            osp_q       <= 1'b0;
            remaining_q <= '0;
            pkt_cnt_q   <= '0;
            need_zlp_q  <= 1'b0;
            txdat_q     <= '0;
            txval_q     <= 1'b0;
            txlast_q    <= 1'b0;
            zlp_q       <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            type_q      <= type_d;
            index_q     <= index_d;
            wlength_q   <= wlength_d;
            hs_q        <= hs_d;
            raddr_q     <= raddr_d;
            base_q      <= base_d;
            osp_q       <= osp_d;
            remaining_q <= remaining_d;
            pkt_cnt_q   <= pkt_cnt_d;
            need_zlp_q  <= need_zlp_d;
            txdat_q     <= txdat_d;
            txval_q     <= txval_d;
            txlast_q    <= txlast_d;
            zlp_q       <= zlp_d;
            stall_q     <= stall_d;
        end
    end

    always_comb begin
        o_descrom_raddr = raddr_q;
        tx.o_txdat      = txdat_q;
        tx.o_txval      = txval_q;
        tx.o_txlast     = txlast_q;
        o_zlp           = zlp_q;
        o_stall         = stall_q;
        o_busy          = (state_q != S_IDLE);
        o_done          = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_usb_desc_reader.sv
// Scoreboard bench for usb_desc_reader: expected bytes are queued per request and
// checked by a monitor on every accepted byte; pulse outputs are counted by the monitor.
module tb_usb_desc_reader;

    localparam int MAXPKT = 64;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        i_abort = 1'b0, i_start = 1'b0, i_hs_mode = 1'b0, i_in_req = 1'b0;
    logic [7:0]  i_desc_type = '0, i_desc_index = '0;
    logic [15:0] i_wlength = '0;
    logic [9:0]  raddr, raddr2;
    logic [7:0]  rdat, rdat2;
    logic [9:0]  dev_addr = 10'd0, hscfg_addr = 10'd32, fscfg_addr = 10'd100, qual_addr = 10'd160;
    logic [9:0]  strlang_addr = 10'd176, vendor_addr = 10'd180, product_addr = 10'd190, serial_addr = 10'd200;
    logic [7:0]  dev_len = 8'd18, hscfg_len = 8'd55, fscfg_len = 8'd55, qual_len = 8'd10;
    logic [7:0]  vendor_len = 8'd6, product_len = 8'd8, serial_len = 8'd10;
    logic        have_strings = 1'b1;
    logic        o_zlp, o_stall, o_busy, o_done;
    logic        o_zlp2, o_stall2, o_busy2, o_done2;
    logic [7:0]  rom [0:1023];
    logic        bp_mode = 1'b0;

    usb_desc_reader_if txif();
    usb_desc_reader_if txif2();

    assign rdat  = rom[raddr];
    assign rdat2 = rom[raddr2];

    usb_desc_reader #(.MAXPKT(MAXPKT), .HSSUPPORT(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .i_abort(i_abort), .i_start(i_start),
        .i_desc_type(i_desc_type), .i_desc_index(i_desc_index), .i_wlength(i_wlength),
        .i_hs_mode(i_hs_mode), .i_in_req(i_in_req),
        .o_descrom_raddr(raddr), .i_descrom_rdat(rdat),
        .i_desc_dev_addr(dev_addr), .i_desc_dev_len(dev_len),
        .i_desc_hscfg_addr(hscfg_addr), .i_desc_hscfg_len(hscfg_len),
        .i_desc_fscfg_addr(fscfg_addr), .i_desc_fscfg_len(fscfg_len),
        .i_desc_qual_addr(qual_addr), .i_desc_qual_len(qual_len),
        .i_desc_strlang_addr(strlang_addr),
        .i_desc_vendor_addr(vendor_addr), .i_desc_vendor_len(vendor_len),
        .i_desc_product_addr(product_addr), .i_desc_product_len(product_len),
        .i_desc_serial_addr(serial_addr), .i_desc_serial_len(serial_len),
        .i_descrom_have_strings(have_strings),
        .tx(txif.master),
        .o_zlp(o_zlp), .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done)
    );

    // Full-speed-only variant sharing the request inputs; only its stall output is checked.
    usb_desc_reader #(.MAXPKT(MAXPKT), .HSSUPPORT(1'b0)) dut_fs (
        .CLK(CLK), .RESET(RESET), .i_abort(i_abort), .i_start(i_start),
        .i_desc_type(i_desc_type), .i_desc_index(i_desc_index), .i_wlength(i_wlength),
        .i_hs_mode(i_hs_mode), .i_in_req(i_in_req),
        .o_descrom_raddr(raddr2), .i_descrom_rdat(rdat2),
        .i_desc_dev_addr(dev_addr), .i_desc_dev_len(dev_len),
        .i_desc_hscfg_addr(hscfg_addr), .i_desc_hscfg_len(hscfg_len),
        .i_desc_fscfg_addr(fscfg_addr), .i_desc_fscfg_len(fscfg_len),
        .i_desc_qual_addr(qual_addr), .i_desc_qual_len(qual_len),
        .i_desc_strlang_addr(strlang_addr),
        .i_desc_vendor_addr(vendor_addr), .i_desc_vendor_len(vendor_len),
        .i_desc_product_addr(product_addr), .i_desc_product_len(product_len),
        .i_desc_serial_addr(serial_addr), .i_desc_serial_len(serial_len),
        .i_descrom_have_strings(have_strings),
        .tx(txif2.master),
        .o_zlp(o_zlp2), .o_stall(o_stall2), .o_busy(o_busy2), .o_done(o_done2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        bit         last;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0, n_total = 0;
    int   done_cnt = 0, zlp_cnt = 0, stall_cnt = 0, stall2_cnt = 0, pkt_cnt = 0, txval_cnt = 0;
    logic prev_val = 1'b0, prev_rdy = 1'b0, prev_abort = 1'b0;
    logic [7:0] prev_dat = '0;

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endfunction

    // Monitor: pops the scoreboard on each accepted byte and counts pulse outputs.
    always @(negedge CLK) begin
        if (RESET) begin
            if (o_done)      done_cnt++;
            if (o_zlp)       zlp_cnt++;
            if (o_stall)     stall_cnt++;
            if (o_stall2)    stall2_cnt++;
            if (txif.o_txval) txval_cnt++;
            if (prev_val && !prev_rdy && !prev_abort) begin
                check("hold_val", int'(txif.o_txval), 1);
                check("hold_dat", int'(txif.o_txdat), int'(prev_dat));
            end
            if (txif.o_txval && txif.i_txrdy) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL spurious_byte: got 0x%02h expected no byte", txif.o_txdat);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("data", int'(txif.o_txdat), int'(e.d));
                    check("last", int'(txif.o_txlast), int'(e.last));
                end
                if (txif.o_txlast) pkt_cnt++;
            end
            prev_val   = txif.o_txval;
            prev_rdy   = txif.i_txrdy;
            prev_dat   = txif.o_txdat;
            prev_abort = i_abort;
        end
    end

    initial begin
        txif.i_txrdy  = 1'b1;
        txif2.i_txrdy = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            txif.i_txrdy = bp_mode ? ~txif.i_txrdy : 1'b1;
        end
    end

    task automatic push_exp(input int base, input int n, input bit osp);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.d    = (osp && k == 1) ? 8'h07 : rom[base + k];
            e.last = ((k % MAXPKT) == MAXPKT - 1) || (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_req(input logic [7:0] t, input logic [7:0] idx,
                             input logic [15:0] wl, input logic hs);
        @(posedge CLK);
        #1;
        i_desc_type  = t;
        i_desc_index = idx;
        i_wlength    = wl;
        i_hs_mode    = hs;
        i_start      = 1'b1;
        @(posedge CLK);
        #1;
        i_start = 1'b0;
    endtask

    task automatic run_xfer(input string name, input int exp_pkts, input int exp_zlp);
        int d0 = done_cnt, z0 = zlp_cnt, p0 = pkt_cnt, s0 = stall_cnt;
        int guard = 0;
        while (done_cnt == d0 && guard < 5000) begin
            int pe = pkt_cnt;
            @(posedge CLK);
            #1 i_in_req = 1'b1;
            @(posedge CLK);
            #1 i_in_req = 1'b0;
            for (int w = 0; w < 300; w++) begin
                @(posedge CLK);
                guard++;
                if (pkt_cnt != pe || done_cnt != d0) break;
            end
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check({name, "_done"}, done_cnt - d0, 1);
        check({name, "_pkts"}, pkt_cnt - p0, exp_pkts);
        check({name, "_zlp"}, zlp_cnt - z0, exp_zlp);
        check({name, "_nostall"}, stall_cnt - s0, 0);
        check({name, "_exp_empty"}, exp_q.size(), 0);
        check({name, "_idle"}, int'(o_busy), 0);
        exp_q.delete();
    endtask

    task automatic stall_test(input string name, input logic [7:0] t, input logic [7:0] idx);
        int tv0 = txval_cnt, s0 = stall_cnt, d0 = done_cnt;
        start_req(t, idx, 16'd255, 1'b1);
        @(negedge CLK);
        check({name, "_stall_t1"}, int'(o_stall), 0);
        @(negedge CLK);
        check({name, "_stall_t2"}, int'(o_stall), 1);
        check({name, "_busy"}, int'(o_busy), 0);
        repeat (5) @(negedge CLK);
        check({name, "_stall_cnt"}, stall_cnt - s0, 1);
        check({name, "_no_txval"}, txval_cnt - tv0, 0);
        check({name, "_no_done"}, done_cnt - d0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, s2;
        for (int i = 0; i < 1024; i++) rom[i] = 8'(i * 7 + 3);
        rom[0] = 8'h12; rom[1] = 8'h01; rom[2] = 8'h00; rom[3] = 8'h02;
        rom[4] = 8'h00; rom[5] = 8'h00; rom[6] = 8'h00; rom[7] = 8'h40;
        rom[32] = 8'h09; rom[33] = 8'h02; rom[34] = 8'h37; rom[35] = 8'h00;
        rom[100] = 8'h09; rom[101] = 8'h02; rom[102] = 8'h37; rom[103] = 8'h00;
        rom[176] = 8'h04; rom[177] = 8'h03; rom[178] = 8'h09; rom[179] = 8'h04;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_txval", int'(txif.o_txval), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_raddr", int'(raddr), 0);
        check("rst_pulses", int'({o_zlp, o_stall, o_done, txif.o_txlast}), 0);
        #1 RESET = 1'b1;

        push_exp(0, 18, 0);
        start_req(8'd1, 8'd0, 16'd64, 1'b1);
        run_xfer("dev64", 1, 0);

        push_exp(0, 8, 0);
        start_req(8'd1, 8'd0, 16'd8, 1'b1);
        run_xfer("dev8", 1, 0);

        push_exp(32, 55, 0);
        start_req(8'd2, 8'd0, 16'd255, 1'b1);
        run_xfer("cfg_hs", 1, 0);

        push_exp(100, 55, 0);
        start_req(8'd2, 8'd0, 16'd255, 1'b0);
        run_xfer("cfg_fs", 1, 0);

        push_exp(32, 55, 1);
        start_req(8'd7, 8'd0, 16'd255, 1'b0);
        run_xfer("osp_fs", 1, 0);

        push_exp(100, 55, 1);
        start_req(8'd7, 8'd0, 16'd255, 1'b1);
        run_xfer("osp_hs", 1, 0);

        push_exp(176, 4, 0);
        start_req(8'd3, 8'd0, 16'd255, 1'b1);
        run_xfer("strlang", 1, 0);

        push_exp(190, 8, 0);
        start_req(8'd3, 8'd2, 16'd255, 1'b1);
        run_xfer("product", 1, 0);

        start_req(8'd1, 8'd0, 16'd0, 1'b1);
        run_xfer("wlen0", 0, 0);

        hscfg_len = 8'd100;
        push_exp(32, 100, 0);
        start_req(8'd2, 8'd0, 16'd255, 1'b1);
        run_xfer("cfg_2pkt", 2, 0);

        hscfg_len = 8'd64;
        push_exp(32, 64, 1);
        start_req(8'd7, 8'd0, 16'd128, 1'b0);
        run_xfer("osp_zlp", 1, 1);
        hscfg_len = 8'd55;

        // Full-speed-only instance must stall a qualifier request the HS instance serves.
        s2 = stall2_cnt;
        push_exp(160, 10, 0);
        start_req(8'd6, 8'd0, 16'd255, 1'b1);
        run_xfer("qual", 1, 0);
        check("qual_fs_stall", stall2_cnt - s2, 1);

        have_strings = 1'b0;
        stall_test("str_nostr", 8'd3, 8'd0);
        have_strings = 1'b1;
        stall_test("str_idx4", 8'd3, 8'd4);
        stall_test("type5", 8'd5, 8'd0);

        bp_mode = 1'b1;
        push_exp(0, 18, 0);
        start_req(8'd1, 8'd0, 16'd64, 1'b1);
        run_xfer("dev_bp", 1, 0);
        bp_mode = 1'b0;
        repeat (2) @(posedge CLK);

        push_exp(0, 18, 0);
        start_req(8'd1, 8'd0, 16'd64, 1'b1);
        @(posedge CLK);
        #1 i_in_req = 1'b1;
        @(posedge CLK);
        #1 i_in_req = 1'b0;
        for (int g = 0; g < 100 && exp_q.size() > 13; g++) begin
            @(posedge CLK);
            #1;
        end
        check("abort_progress", int'(exp_q.size() <= 13), 1);
        d0 = done_cnt;
        i_abort = 1'b1;
        @(posedge CLK);
        #1 i_abort = 1'b0;
        @(negedge CLK);
        check("abort_txval", int'(txif.o_txval), 0);
        check("abort_txlast", int'(txif.o_txlast), 0);
        check("abort_busy", int'(o_busy), 0);
        exp_q.delete();
        repeat (10) @(negedge CLK);
        check("abort_no_done", done_cnt - d0, 0);

        @(posedge CLK);
        #1;
        i_desc_type = 8'd1;
        i_wlength   = 16'd64;
        i_abort     = 1'b1;
        i_start     = 1'b1;
        @(posedge CLK);
        #1;
        i_abort = 1'b0;
        i_start = 1'b0;
        @(negedge CLK);
        check("abort_start_busy", int'(o_busy), 0);
        repeat (5) @(negedge CLK);
        check("abort_start_idle", int'(o_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/usb_desc_reader.md
Name: usb_desc_reader

Overview:
- Control-endpoint descriptor streamer; sits directly downstream of the descriptor ROM.
- On a decoded GET_DESCRIPTOR request it resolves the ROM address and length from the ROM's address/length outputs.
- It registers the ROM read address, fetches bytes, and streams them to the EP0 IN path with valid/ready.
- It packetizes to the EP0 max packet size, truncates to wLength, and emits a zero-length packet (ZLP) or stall when required.

Parameters:
- MAXPKT, 64, EP0 max packet size in bytes (power of two, 8..64).
- HSSUPPORT, 1, device supports high speed; 0 makes device qualifier and other-speed config requests stall.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- i_abort  in  1  new SETUP seen or bus reset; forces IDLE.
- i_start  in  1  one-cycle pulse; GET_DESCRIPTOR request decoded.
- i_desc_type  in  8  wValue high byte: 1 dev, 2 cfg, 3 string, 6 qual, 7 other-speed.
- i_desc_index  in  8  wValue low byte.
- i_wlength  in  16  host wLength.
- i_hs_mode  in  1  current link is high speed.
- i_in_req  in  1  pulse; host IN token, EP0 buffer ready for next packet.
- o_descrom_raddr  out  10  registered ROM address.
- i_descrom_rdat  in  8  ROM data, combinational from o_descrom_raddr.
- i_desc_*_addr/len, i_descrom_have_strings  in  10/8/1  ROM map; same set the ROM exports.
- o_txdat  out  8  stream byte.
- o_txval  out  1  byte valid.
- i_txrdy  in  1  sink accepts byte.
- o_txlast  out  1  with o_txval: last byte of the current packet.
- o_zlp  out  1  one-cycle pulse; send zero-length packet.
- o_stall  out  1  one-cycle pulse; request unsupported.
- o_busy  out  1  not IDLE.
- o_done  out  1  one-cycle pulse after the final packet is handed off.

Behaviour:
- Reset values: every output 0; o_descrom_raddr 0; state IDLE.
- States: IDLE, LOOKUP, WAIT_IN, SEND, ZLP_WAIT, DONE.
- IDLE: i_start latches the request and moves to LOOKUP. i_start outside IDLE is ignored.
- LOOKUP (1 cycle): select base address and desc_len.
  - type 1: dev.
  - type 2: hscfg if i_hs_mode, else fscfg.
  - type 6: qual.
  - type 7: fscfg if i_hs_mode, else hscfg; byte offset 1 is replaced by 8'h07.
  - type 3: index 0 strlang with length 4; index 1/2/3 vendor/product/serial with their lens.
  - Stall conditions: any other type; string index >3; string with have_strings=0; type 6/7 with HSSUPPORT=0. A stall pulses o_stall and returns to IDLE.
  - xfer_len = min(desc_len, i_wlength), 16-bit compare.
  - need_zlp = (xfer_len < i_wlength) && (xfer_len % MAXPKT == 0). This covers xfer_len=0 with wLength>0.
  - Sets o_descrom_raddr = base; then to WAIT_IN.
- WAIT_IN: if remaining==0, go to ZLP_WAIT when need_zlp, else to DONE. Otherwise i_in_req loads pkt_cnt = min(remaining, MAXPKT) and goes to SEND.
- SEND: single output register with prefetch.
  - Load when (!o_txval || i_txrdy) and bytes remain in the packet.
  - On load: o_txdat <= rdat (or 8'h07 at the substituted offset); raddr++; pkt_cnt--; remaining--.
  - o_txlast set on the load where pkt_cnt reaches 0.
  - Throughput is 1 byte/cycle under continuous ready. First o_txval rises 1 cycle after i_in_req.
  - o_txval/o_txdat hold stable while !i_txrdy.
  - When the last byte is accepted (o_txval & o_txlast & i_txrdy), return to WAIT_IN.
- ZLP_WAIT: i_in_req causes an o_zlp pulse, then DONE.
- DONE: o_done pulse, then IDLE.
- i_abort: highest priority in any state. Next cycle state is IDLE, o_txval and o_txlast are 0, and no done/stall pulse is issued. i_abort and i_start in the same cycle: abort wins.
- i_in_req outside WAIT_IN/ZLP_WAIT is ignored.
- Counters: remaining 16 bit, pkt_cnt 7 bit. ROM address arithmetic is 10-bit and never exceeds base+desc_len.

Test Plan:
- Device descriptor, wLength=64, ready=1 -> one 18-byte packet 12 01 00 02 ..., o_txlast on byte 18, no ZLP, o_done.
- Device descriptor, wLength=8 -> 8 bytes 12 01 00 02 00 00 00 40, o_txlast on byte 8, no ZLP.
- Config in HS, wLength=255 (hscfg len 55) -> 55 bytes; byte 0 = 09, byte 1 = 02, byte 2 = 37; no ZLP.
- Other-speed, i_hs_mode=0 -> 55 hscfg bytes with byte 1 = 07. Then length forced to 64 with wLength=128 -> packet of 64, then o_zlp on the second i_in_req.
- String type 3 with have_strings=0 -> o_stall pulse 2 cycles after i_start, no o_txval. Type 6 with HSSUPPORT=0 -> stall.
- Backpressure toggling i_txrdy every other cycle -> byte order and data unchanged, o_txdat stable while stalled. i_abort mid-packet -> o_txval low and o_busy low next cycle, no o_done.
